// File: rtl/rx232_frame_rx.sv
// rtl/rx232_frame_rx.sv - RS-232 frame deserializer with 1-entry valid/ready output register
//
// Purpose:
//   Takes the recovered bit clock (rxck) and retimed serial bit (rxsdo) from the
//   bit-clock recovery stage, finds the start bit, shifts DATA_BITS data bits in
//   LSB first, checks the stop bit and hands good bytes out through a 1-entry
//   valid/ready register.
//
// Optional feature macro: RX232_PARITY_EN
//   Defined   : frame = start + data + parity + stop; parity checked against PARITY_ODD.
//   Undefined : frame = start + data + stop; par_err tied to 0.
//
// Ports:
//   clk       in   1          system clock
//   rst       in   1          asynchronous active-high reset
//   rxck      in   1          recovered bit clock, rising transition = bit event
//   rxsdo     in   1          serial bit, idle = 1
//   rx_data   out  DATA_BITS  received byte, valid while rx_valid = 1
//   rx_valid  out  1          output register holds an unconsumed byte
//   rx_ready  in   1          consumer accepts when rx_valid & rx_ready
//   frm_err   out  1          1-cycle pulse: stop bit was 0
//   ovr_err   out  1          1-cycle pulse: good frame dropped, output register full
//   par_err   out  1          1-cycle pulse: parity mismatch (0 without RX232_PARITY_EN)

module rx232_frame_rx #(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxck,
    input  logic                 rxsdo,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frm_err,
    output logic                 ovr_err,
    output logic                 par_err
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
`ifdef RX232_PARITY_EN
        PAR,
`endif
        STOP,
        WAIT1
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    state_t               state;
    logic                 rxck_d;
    logic [DATA_BITS-1:0] sh;
    logic [3:0]           bcnt;
    logic                 bev;
    logic                 parity_ok;

    assign bev = rxck & ~rxck_d;

`ifdef RX232_PARITY_EN
    logic pbit;
    assign parity_ok = ((^{sh, pbit}) == PARITY_ODD);
`else
    assign parity_ok = 1'b1;
    assign par_err   = 1'b0;
    wire unused_parity_odd = PARITY_ODD;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rxck_d   <= 1'b0;
            sh       <= '0;
            bcnt     <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            frm_err  <= 1'b0;
            ovr_err  <= 1'b0;
`ifdef RX232_PARITY_EN
            pbit     <= 1'b0;
            par_err  <= 1'b0;
`endif
        end else begin
            rxck_d  <= rxck;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
`ifdef RX232_PARITY_EN
            par_err <= 1'b0;
`endif
            // Consumer handshake; a load at the STOP bev below overrides this clear.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (bev) begin
                case (state)
                    IDLE: begin
                        if (!rxsdo) begin
                            state <= DATA;
                            bcnt  <= '0;
                        end
                    end
                    DATA: begin
                        sh   <= {rxsdo, sh[DATA_BITS-1:1]};
                        bcnt <= bcnt + 4'd1;
                        if (bcnt == LAST_BIT) begin
`ifdef RX232_PARITY_EN
                            state <= PAR;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef RX232_PARITY_EN
                    PAR: begin
                        pbit  <= rxsdo;
                        state <= STOP;
                    end
`endif
                    STOP: begin
                        // Precedence: framing, then parity, then overrun.
                        if (!rxsdo) begin
                            frm_err <= 1'b1;
                            state   <= WAIT1;
                        end else begin
                            state <= IDLE;
                            if (!parity_ok) begin
`ifdef RX232_PARITY_EN
                                par_err <= 1'b1;
`endif
                            end else if (!rx_valid || rx_ready) begin
                                rx_data  <= sh;
                                rx_valid <= 1'b1;
                            end else begin
                                ovr_err <= 1'b1;
                            end
                        end
                    end
                    WAIT1: begin
                        // Hold off until the line returns high so a break is not a start bit.
                        if (rxsdo) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx232_frame_rx.sv
// tb/tb_rx232_frame_rx.sv - directed self-checking bench for rx232_frame_rx

module tb_rx232_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxck = 1'b0;
    logic       rxsdo = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frm_err;
    logic       ovr_err;
    logic       par_err;

    int errors = 0;
    int checks = 0;

    int         n_xfer = 0;
    int         n_vcyc = 0;
    int         n_frm = 0;
    int         n_ovr = 0;
    int         n_par = 0;
    logic [7:0] last_data = 8'h00;

    int s_xfer, s_vcyc, s_frm, s_ovr, s_par;

    rx232_frame_rx #(.DATA_BITS(8), .PARITY_ODD(1'b0)) dut (
        .clk      (clk),
        .rst      (rst),
        .rxck     (rxck),
        .rxsdo    (rxsdo),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frm_err  (frm_err),
        .ovr_err  (ovr_err),
        .par_err  (par_err)
    );

    always #5 clk = ~clk;

    // Observe away from the active edge; inputs are driven at posedge+1.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            n_xfer    <= n_xfer + 1;
            last_data <= rx_data;
        end
        if (rx_valid) n_vcyc <= n_vcyc + 1;
        if (frm_err)  n_frm  <= n_frm + 1;
        if (ovr_err)  n_ovr  <= n_ovr + 1;
        if (par_err)  n_par  <= n_par + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_xfer = n_xfer;
        s_vcyc = n_vcyc;
        s_frm  = n_frm;
        s_ovr  = n_ovr;
        s_par  = n_par;
    endtask

    // One bit cell: rxck low 8 clk (rxsdo changes at the fall), then high 8 clk.
    task automatic send_bit(input logic b);
        rxsdo = b;
        rxck  = 1'b0;
        repeat (8) tick();
        rxck = 1'b1;
        repeat (8) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

`ifdef RX232_PARITY_EN
    task automatic send_frame_p(input logic [7:0] d, input logic p, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stop);
    endtask
`endif

    initial begin
        // Reset state
        tick();
        repeat (3) tick();
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data",  32'(rx_data),  32'h00);
        check("rst_frm",   32'(frm_err),  32'd0);
        check("rst_ovr",   32'(ovr_err),  32'd0);
        check("rst_par",   32'(par_err),  32'd0);
        rst = 1'b0;
        tick();

        // 1: idle then 0x55 with ready high
        rx_ready = 1'b1;
        snap();
        send_bit(1'b1);
        send_bit(1'b1);
        check("t1_idle_novalid", 32'(n_vcyc - s_vcyc), 32'd0);
        send_frame(8'h55, 1'b1);
        send_bit(1'b1);
        check("t1_xfer_cnt",   32'(n_xfer - s_xfer), 32'd1);
        check("t1_valid_cyc",  32'(n_vcyc - s_vcyc), 32'd1);
        check("t1_data",       32'(last_data),       32'h55);
        check("t1_no_err",     32'((n_frm - s_frm) + (n_ovr - s_ovr) + (n_par - s_par)), 32'd0);

        // 2: framing error, break, recovery, then 0x3C
        snap();
        send_frame(8'hA3, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        check("t2_frm_once",   32'(n_frm - s_frm),   32'd1);
        check("t2_no_valid",   32'(n_vcyc - s_vcyc), 32'd0);
        send_bit(1'b1);
        send_frame(8'h3C, 1'b1);
        send_bit(1'b1);
        check("t2_frm_total",  32'(n_frm - s_frm),   32'd1);
        check("t2_xfer_cnt",   32'(n_xfer - s_xfer), 32'd1);
        check("t2_data",       32'(last_data),       32'h3C);

        // 3: overrun with ready low
        rx_ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1);
        send_bit(1'b1);
        check("t3_valid_11",   32'(rx_valid),        32'd1);
        check("t3_data_11",    32'(rx_data),         32'h11);
        send_frame(8'h22, 1'b1);
        send_bit(1'b1);
        check("t3_ovr_once",   32'(n_ovr - s_ovr),   32'd1);
        check("t3_data_held",  32'(rx_data),         32'h11);
        check("t3_no_xfer",    32'(n_xfer - s_xfer), 32'd0);
        rx_ready = 1'b1;
        tick();
        check("t3_valid_drop", 32'(rx_valid),        32'd0);
        check("t3_xfer_data",  32'(last_data),       32'h11);
        check("t3_xfer_cnt",   32'(n_xfer - s_xfer), 32'd1);

        // 4: reset in the middle of 0xF0, then 0x81
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        rst = 1'b1;
        send_bit(1'b1);
        check("t4_rst_valid",  32'(rx_valid),        32'd0);
        check("t4_rst_data",   32'(rx_data),         32'h00);
        rst = 1'b0;
        send_bit(1'b1);
        send_frame(8'h81, 1'b1);
        send_bit(1'b1);
        check("t4_xfer_cnt",   32'(n_xfer - s_xfer), 32'd1);
        check("t4_data",       32'(last_data),       32'h81);
        check("t4_no_err",     32'((n_frm - s_frm) + (n_ovr - s_ovr) + (n_par - s_par)), 32'd0);

        // 5: ready rises in the same cycle a new byte loads
        rx_ready = 1'b0;
        send_frame(8'h10, 1'b1);
        send_bit(1'b1);
        check("t5_hold_10",    32'(rx_data),         32'h10);
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h20 >> i));
        rxsdo = 1'b1;
        rxck  = 1'b0;
        repeat (8) tick();
        rxck     = 1'b1;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        repeat (7) tick();
        check("t5_no_ovr",     32'(n_ovr - s_ovr),   32'd0);
        check("t5_valid",      32'(rx_valid),        32'd1);
        check("t5_data_20",    32'(rx_data),         32'h20);
        check("t5_xfer_10",    32'(last_data),       32'h10);
        rx_ready = 1'b1;
        tick();
        check("t5_drain",      32'(last_data),       32'h20);
        check("t5_valid_drop", 32'(rx_valid),        32'd0);

`ifdef RX232_PARITY_EN
        // 6: even parity
        snap();
        send_frame_p(8'h07, 1'b1, 1'b1);
        send_bit(1'b1);
        check("t6_good_xfer",  32'(n_xfer - s_xfer), 32'd1);
        check("t6_good_data",  32'(last_data),       32'h07);
        check("t6_good_nopar", 32'(n_par - s_par),   32'd0);
        snap();
        send_frame_p(8'h07, 1'b0, 1'b1);
        send_bit(1'b1);
        check("t6_bad_par",    32'(n_par - s_par),   32'd1);
        check("t6_bad_novld",  32'(n_vcyc - s_vcyc), 32'd0);
`else
        check("par_tied_zero", 32'(n_par),           32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
